// File: rtl/dekatron_seek_sequencer_pkg.sv
// dekatron_seek_sequencer_pkg: shared digit width and sequencer state type
package dekatron_seek_sequencer_pkg;
  localparam int DEKATRON_WIDTH = 4;
  typedef enum logic [2:0] {IDLE, SET_PULSE, STEP_REQ, STEP_WAIT, DONE, ERROR} seq_state_t;
endpackage

// File: rtl/dekatron_seek_sequencer_if.sv
// dekatron_seek_sequencer_if: command and counter-side signals of the seek sequencer
interface dekatron_seek_sequencer_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 16
);
  logic              start;
  logic              use_set;
  logic [WIDTH-1:0]  target;
  logic              busy;
  logic              done;
  logic              error;
  logic [STEP_W-1:0] steps;
  logic              cnt_request;
  logic              cnt_dec;
  logic              cnt_set;
  logic [WIDTH-1:0]  cnt_in;
  logic              cnt_ready;
  logic [WIDTH-1:0]  cnt_out;
  modport master (
    input  start, use_set, target, cnt_ready, cnt_out,
    output busy, done, error, steps, cnt_request, cnt_dec, cnt_set, cnt_in
  );
  modport slave (
    output start, use_set, target, cnt_ready, cnt_out,
    input  busy, done, error, steps, cnt_request, cnt_dec, cnt_set, cnt_in
  );
endinterface

// File: rtl/dekatron_seek_sequencer_bcd_compare.sv
// bcd_compare: unsigned magnitude compare of digit-packed BCD values, most significant digit first
module bcd_compare
  import dekatron_seek_sequencer_pkg::*;
#(
  parameter int D_NUM = 1
) (
  input  logic [D_NUM*DEKATRON_WIDTH-1:0] a,
  input  logic [D_NUM*DEKATRON_WIDTH-1:0] b,
  output logic                            lt,
  output logic                            eq
);
  always_comb begin
    lt = 1'b0;
    eq = 1'b1;
    for (int i = D_NUM - 1; i >= 0; i--)
      if (eq) begin
        lt = a[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] < b[i*DEKATRON_WIDTH +: DEKATRON_WIDTH];
        eq = a[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] == b[i*DEKATRON_WIDTH +: DEKATRON_WIDTH];
      end
  end
endmodule

// File: rtl/dekatron_seek_sequencer.sv
// dekatron_seek_sequencer: drives a dekatron counter to a target by stepping or direct set
module dekatron_seek_sequencer
  import dekatron_seek_sequencer_pkg::*;
#(
  parameter int D_NUM   = 1,
  parameter int WIDTH   = D_NUM * DEKATRON_WIDTH,
  parameter int TIMEOUT = 255,
  parameter int STEP_W  = 16
) (
  input logic clk,
  input logic rst,
  dekatron_seek_sequencer_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  seq_state_t        state, state_n;
  logic [WIDTH-1:0]  tgt;
  logic [WD_W-1:0]   wd;
  logic [STEP_W-1:0] steps;
  logic              set_op, dec_r, lt, eq, accept, req;
  bcd_compare #(.D_NUM(D_NUM)) u_cmp (.a(bus.cnt_out), .b(tgt), .lt(lt), .eq(eq));
  assign accept          = state == IDLE && bus.start && bus.cnt_ready;
  assign req             = state == STEP_REQ && !eq;
  assign bus.busy        = state inside {SET_PULSE, STEP_REQ, STEP_WAIT};
  assign bus.done        = state == DONE;
  assign bus.error       = state == ERROR;
  assign bus.cnt_request = req;
  assign bus.cnt_set     = state == SET_PULSE;
  assign bus.cnt_dec     = state == STEP_REQ ? !eq && !lt : state == STEP_WAIT && !set_op && dec_r;
  assign bus.cnt_in      = tgt;
  assign bus.steps       = steps;
  // Ready lags Request/Set by a cycle, so the first wait cycle (wd == 0) ignores it
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (accept) state_n = bus.use_set ? SET_PULSE : STEP_REQ;
      SET_PULSE: state_n = STEP_WAIT;
      STEP_REQ:  state_n = eq ? DONE : STEP_WAIT;
      STEP_WAIT: if (wd != '0 && bus.cnt_ready) state_n = !set_op ? STEP_REQ : eq ? DONE : ERROR;
                 else if (wd == WD_W'(TIMEOUT - 1)) state_n = ERROR;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tgt    <= '0;
      wd     <= '0;
      set_op <= 1'b0;
      dec_r  <= 1'b0;
      steps  <= '0;
    end else begin
      state <= state_n;
      wd    <= (state == STEP_WAIT && state_n == STEP_WAIT) ? wd + 1'b1 : '0;
      if (state == STEP_REQ) dec_r <= !lt;
      if (accept) begin
        tgt    <= bus.target;
        set_op <= bus.use_set;
        steps  <= '0;
      end else if (req && !(&steps)) steps <= steps + 1'b1;
    end
  end
endmodule

// File: tb/tb_dekatron_seek_sequencer.sv
// tb_dekatron_seek_sequencer: directed bench with a behavioural BCD counter and result scoreboard
module tb_dekatron_seek_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dekatron_seek_sequencer_if #(.WIDTH(8), .STEP_W(16)) bus ();
  dekatron_seek_sequencer #(.D_NUM(2), .WIDTH(8), .TIMEOUT(8), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  typedef struct {
    logic err;
    int   steps;
    int   pulses;
    int   decs;
    int   sets;
    int   lat;
  } exp_t;
  exp_t sb[$];
  logic [7:0] cnt_val, load_val, last_set_in;
  logic       rdy, stuck, load_en;
  int checks = 0, errors = 0;
  int tot_req = 0, tot_dec = 0, tot_set = 0, overlap = 0;
  assign bus.cnt_out   = cnt_val;
  assign bus.cnt_ready = rdy;
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic d);
    int n;
    n = v[7:4] * 10 + v[3:0];
    n = d ? (n + 99) % 100 : (n + 1) % 100;
    return {4'(n / 10), 4'(n % 10)};
  endfunction
  // counter model: Ready drops for one cycle after each Request or Set
  always @(posedge clk) begin
    if (rst) begin
      cnt_val <= 8'h00;
      rdy     <= 1'b1;
    end else if (load_en) begin
      cnt_val <= load_val;
      rdy     <= 1'b1;
    end else if (bus.cnt_request) begin
      cnt_val <= bcd_step(cnt_val, bus.cnt_dec);
      rdy     <= 1'b0;
    end else if (bus.cnt_set) begin
      cnt_val <= bus.cnt_in;
      rdy     <= 1'b0;
    end else rdy <= !stuck;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cnt_request) begin
        tot_req++;
        if (bus.cnt_dec) tot_dec++;
      end
      if (bus.cnt_set) begin
        tot_set++;
        last_set_in = bus.cnt_in;
      end
      if (bus.cnt_request && bus.cnt_set) overlap++;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [7:0] ld, input logic [7:0] tg, input logic us, input logic stk, input exp_t e);
    int r0, d0, s0, lat;
    exp_t x;
    @(negedge clk);
    load_en  = 1'b1;
    load_val = ld;
    @(negedge clk);
    load_en = 1'b0;
    r0 = tot_req;
    d0 = tot_dec;
    s0 = tot_set;
    sb.push_back(e);
    bus.target  = tg;
    bus.use_set = us;
    bus.start   = 1'b1;
    stuck       = stk;
    lat         = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
    end while (!(bus.done || bus.error) && lat < 100);
    x = sb.pop_front();
    chk("end_pulse", 32'(bus.done | bus.error), 1);
    chk("error_flag", 32'(bus.error), 32'(x.err));
    chk("busy_at_end", 32'(bus.busy), 0);
    chk("steps", 32'(bus.steps), x.steps);
    chk("req_pulses", tot_req - r0, x.pulses);
    chk("dec_pulses", tot_dec - d0, x.decs);
    chk("set_pulses", tot_set - s0, x.sets);
    if (x.lat > 0) chk("latency", lat, x.lat);
    if (!x.err) chk("final_count", 32'(cnt_val), 32'(tg));
    stuck = 1'b0;
    @(negedge clk);
    chk("pulse_one_cycle", 32'(bus.done | bus.error), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end
  initial begin
    exp_t e;
    int   lat, n;
    bus.start   = 1'b0;
    bus.use_set = 1'b0;
    bus.target  = 8'h00;
    stuck       = 1'b0;
    load_en     = 1'b0;
    load_val    = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done_err", 32'(bus.done | bus.error), 0);
    chk("rst_req_set", 32'(bus.cnt_request | bus.cnt_set), 0);
    chk("rst_dec", 32'(bus.cnt_dec), 0);
    chk("rst_steps", 32'(bus.steps), 0);
    chk("rst_cnt_in", 32'(bus.cnt_in), 0);
    rst = 1'b0;
    e = '{1'b0, 4, 4, 0, 0, 0};
    run_op(8'h03, 8'h07, 1'b0, 1'b0, e);
    e = '{1'b0, 2, 2, 2, 0, 0};
    run_op(8'h50, 8'h48, 1'b0, 1'b0, e);
    e = '{1'b0, 0, 0, 0, 0, 2};
    run_op(8'h21, 8'h21, 1'b0, 1'b0, e);
    e = '{1'b0, 0, 0, 0, 1, 4};
    run_op(8'h12, 8'h95, 1'b1, 1'b0, e);
    chk("set_cnt_in", 32'(last_set_in), 32'h95);
    stuck = 1'b1;
    repeat (2) @(negedge clk);
    bus.target  = 8'h44;
    bus.use_set = 1'b0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_not_ready_busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("start_not_ready_req", 32'(bus.cnt_request | bus.busy), 0);
    stuck = 1'b0;
    @(negedge clk);
    e = '{1'b1, 1, 1, 0, 0, 10};
    run_op(8'h10, 8'h12, 1'b0, 1'b1, e);
    @(negedge clk);
    load_en  = 1'b1;
    load_val = 8'h00;
    @(negedge clk);
    load_en     = 1'b0;
    bus.target  = 8'h05;
    bus.start   = 1'b1;
    lat         = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
    end while (!bus.cnt_request && lat < 20);
    chk("mid_req_seen", 32'(bus.cnt_request), 1);
    @(negedge clk);
    chk("mid_busy_wait", 32'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_req_set_dec", 32'(bus.cnt_request | bus.cnt_set | bus.cnt_dec), 0);
    chk("mid_rst_steps", 32'(bus.steps), 0);
    chk("mid_rst_cnt_in", 32'(bus.cnt_in), 0);
    rst = 1'b0;
    n   = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.error || bus.busy) n++;
    end
    chk("mid_rst_no_pulse", n, 0);
    e = '{1'b0, 0, 0, 0, 0, 2};
    run_op(8'h33, 8'h33, 1'b0, 1'b0, e);
    chk("req_set_overlap", overlap, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
